// File: rtl/mapper_irq_pkg.sv
// Shared constants for the mapper IRQ prescaler/counter block: register
// indices ($C000..$C007 map to 0..7), the clock-source enum and MODE bit positions.
package mapper_irq_pkg;

    localparam logic [2:0] IRQ_REG_CTRL   = 3'd0;
    localparam logic [2:0] IRQ_REG_MODE   = 3'd1;
    localparam logic [2:0] IRQ_REG_DIS    = 3'd2;
    localparam logic [2:0] IRQ_REG_EN     = 3'd3;
    localparam logic [2:0] IRQ_REG_PRE    = 3'd4;
    localparam logic [2:0] IRQ_REG_CNT_LO = 3'd5;
    localparam logic [2:0] IRQ_REG_XOR    = 3'd6;
    localparam logic [2:0] IRQ_REG_CNT_HI = 3'd7;

    typedef enum logic [1:0] {
        SRC_M2    = 2'b00,
        SRC_A12   = 2'b01,
        SRC_PPURD = 2'b10,
        SRC_CPUWR = 2'b11
    } irq_src_e;

    localparam int MODE_SRC_LSB    = 0;
    localparam int MODE_SMALL_BIT  = 2;
    localparam int MODE_RELOAD_BIT = 3;
    localparam int MODE_DIR_LSB    = 6;

    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/a12_edge_detect.sv
// PPU A12 rising-edge detector. old_a12 is sampled only on ppu_ce.
// With MAPPER_IRQ_A12_FILTER_EN defined, a rise only counts after A12 has
// been sampled low on at least A12_LOW_MIN consecutive ppu_ce cycles.
module a12_edge_detect
`ifdef MAPPER_IRQ_A12_FILTER_EN
#(
    parameter int A12_LOW_MIN = 3
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic ppu_ce,
    input  logic a12,
    output logic rise
);

    logic old_a12;

    // Previous A12 sample, advanced only on PPU cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            old_a12 <= 1'b0;
        end else if (ppu_ce) begin
            old_a12 <= a12;
        end
    end

`ifdef MAPPER_IRQ_A12_FILTER_EN
    localparam int RUN_W = (A12_LOW_MIN < 1) ? 1 : $clog2(A12_LOW_MIN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(A12_LOW_MIN);

    logic [RUN_W-1:0] low_run;

    // Count consecutive low samples, saturating; any high sample restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_run <= '0;
        end else if (ppu_ce) begin
            if (a12) begin
                low_run <= '0;
            end else if (low_run != RUN_MAX) begin
                low_run <= low_run + 1'b1;
            end
        end
    end

    assign rise = ppu_ce && a12 && !old_a12 && (low_run == RUN_MAX);
`else
    assign rise = ppu_ce && a12 && !old_a12;
`endif

endmodule

// File: rtl/mapper_irq_counter.sv
// Prescaled IRQ counter for JY-Company-class NES mappers. Up/down counting
// gated by one of four sources, optional 3-bit prescaler and auto-reload.
// Optional A12 glitch filter: define MAPPER_IRQ_A12_FILTER_EN.
module mapper_irq_counter
    import mapper_irq_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PRE_W = 8
`ifdef MAPPER_IRQ_A12_FILTER_EN
    ,
    parameter int A12_LOW_MIN = 3
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             ppu_ce,
    input  logic             reg_wr,
    input  logic [2:0]       reg_addr,
    input  logic [7:0]       reg_din,
    input  logic             a12,
    input  logic             chr_read,
    input  logic             prg_write,
    output logic             irq,
    output logic [CNT_W-1:0] count,
    output logic [PRE_W-1:0] prescaler
);

    localparam logic [CNT_W-1:0] LO_MASK = CNT_W'(8'hFF);

    logic             irq_enable;
    logic             irq_pending;
    irq_src_e         mode_src;
    logic             mode_small;
    logic             mode_reload;
    logic [1:0]       mode_dir;
    logic [7:0]       xor_key;
    logic [CNT_W-1:0] reload;

    logic             a12_rise;
    logic             wr;
    logic [7:0]       dx;
    logic             do_enable;
    logic             do_disable;
    logic             wr_pre;
    logic             wr_lo;
    logic             wr_hi;
    logic             src_event;
    logic             dir_up;
    logic             tick;
    logic             pre_carry;
    logic             cnt_term;
    logic [PRE_W-1:0] pre_step;
    logic [CNT_W-1:0] cnt_step;
    logic [CNT_W-1:0] cnt_lo_val;
    logic [CNT_W-1:0] cnt_hi_val;
    logic [CNT_W-1:0] rel_lo_val;
    logic [CNT_W-1:0] rel_hi_val;

    a12_edge_detect
`ifdef MAPPER_IRQ_A12_FILTER_EN
    #(
        .A12_LOW_MIN(A12_LOW_MIN)
    )
`endif
    u_a12 (
        .clk    (clk),
        .reset  (reset),
        .ppu_ce (ppu_ce),
        .a12    (a12),
        .rise   (a12_rise)
    );

    assign wr         = ce && reg_wr;
    assign dx         = reg_din ^ xor_key;
    assign do_disable = wr && ((reg_addr == IRQ_REG_DIS) ||
                               (reg_addr == IRQ_REG_CTRL && !reg_din[0]));
    assign do_enable  = wr && ((reg_addr == IRQ_REG_EN) ||
                               (reg_addr == IRQ_REG_CTRL && reg_din[0]));
    assign wr_pre     = wr && (reg_addr == IRQ_REG_PRE);
    assign wr_lo      = wr && (reg_addr == IRQ_REG_CNT_LO);
    assign wr_hi      = wr && (reg_addr == IRQ_REG_CNT_HI) && (CNT_W > 8);

    assign irq = irq_pending && irq_enable;

    // Source selection, prescaler/counter step values and terminal detection.
    always_comb begin
        src_event = 1'b0;
        case (mode_src)
            SRC_M2:    src_event = ce;
            SRC_A12:   src_event = a12_rise;
            SRC_PPURD: src_event = ppu_ce && chr_read;
            SRC_CPUWR: src_event = ce && prg_write;
            default:   src_event = 1'b0;
        endcase

        dir_up = (mode_dir == DIR_UP);

        // A counter/prescaler write or a disable on the same edge swallows the tick.
        tick = src_event && irq_enable && (mode_dir[1] != mode_dir[0]) &&
               !do_disable && !wr_pre && !wr_lo && !wr_hi;

        if (mode_small) begin
            pre_carry = dir_up ? (&prescaler[2:0]) : (~|prescaler[2:0]);
        end else begin
            pre_carry = dir_up ? (&prescaler) : (~|prescaler);
        end
        pre_step = dir_up ? prescaler + 1'b1 : prescaler - 1'b1;

        cnt_term = dir_up ? (&count) : (~|count);
        if (cnt_term && mode_reload) begin
            cnt_step = reload;
        end else begin
            cnt_step = dir_up ? count + 1'b1 : count - 1'b1;
        end

        cnt_lo_val = (count  & ~LO_MASK) | CNT_W'(dx);
        rel_lo_val = (reload & ~LO_MASK) | CNT_W'(dx);
        cnt_hi_val = (count  &  LO_MASK) | CNT_W'({dx, 8'h00});
        rel_hi_val = (reload &  LO_MASK) | CNT_W'({dx, 8'h00});
    end

    // Register file and counting: reset > disable > loads > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_enable  <= 1'b0;
            irq_pending <= 1'b0;
            mode_src    <= SRC_M2;
            mode_small  <= 1'b0;
            mode_reload <= 1'b0;
            mode_dir    <= 2'b00;
            xor_key     <= 8'h00;
            reload      <= '0;
            count       <= '0;
            prescaler   <= '0;
        end else if (do_disable) begin
            irq_enable  <= 1'b0;
            irq_pending <= 1'b0;
            prescaler   <= '0;
        end else begin
            if (do_enable) begin
                irq_enable <= 1'b1;
            end
            if (wr && reg_addr == IRQ_REG_MODE) begin
                mode_src    <= irq_src_e'(reg_din[MODE_SRC_LSB +: 2]);
                mode_small  <= reg_din[MODE_SMALL_BIT];
                mode_reload <= reg_din[MODE_RELOAD_BIT];
                mode_dir    <= reg_din[MODE_DIR_LSB +: 2];
            end
            if (wr && reg_addr == IRQ_REG_XOR) begin
                xor_key <= reg_din;
            end
            if (wr_pre) begin
                prescaler <= PRE_W'(dx);
            end
            if (wr_lo) begin
                count  <= cnt_lo_val;
                reload <= rel_lo_val;
            end
            if (wr_hi) begin
                count  <= cnt_hi_val;
                reload <= rel_hi_val;
            end
            if (tick) begin
                prescaler <= pre_step;
                if (pre_carry) begin
                    count <= cnt_step;
                    if (cnt_term) begin
                        irq_pending <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mapper_irq_counter.sv
// Bench for mapper_irq_counter: an 8-bit and a 16-bit counter instance share
// one input stream and are compared every cycle with an arithmetic model,
// plus directed checkpoints for the documented scenarios.
module tb_mapper_irq_counter;

    localparam int LOW_MIN = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        ppu_ce;
    logic        reg_wr;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_din;
    logic        a12;
    logic        chr_read;
    logic        prg_write;
    logic        irq8;
    logic [7:0]  count8;
    logic [7:0]  pre8;
    logic        irq16;
    logic [15:0] count16;
    logic [7:0]  pre16;

    int n_vec = 0;
    int n_err = 0;

    // model state, index 0 = 8-bit counter, 1 = 16-bit counter
    int cw[2] = '{8, 16};
    int m_en[2], m_pend[2], m_src[2], m_small[2], m_rel_en[2], m_dir[2];
    int m_xor[2], m_pre[2], m_cnt[2], m_rel[2];
    int m_old_a12, m_low_run;

    always #5 clk = ~clk;

    mapper_irq_counter #(.CNT_W(8), .PRE_W(8)) dut8 (
        .clk(clk), .reset(reset), .ce(ce), .ppu_ce(ppu_ce), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_din(reg_din), .a12(a12), .chr_read(chr_read),
        .prg_write(prg_write), .irq(irq8), .count(count8), .prescaler(pre8)
    );

    mapper_irq_counter #(.CNT_W(16), .PRE_W(8)) dut16 (
        .clk(clk), .reset(reset), .ce(ce), .ppu_ce(ppu_ce), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_din(reg_din), .a12(a12), .chr_read(chr_read),
        .prg_write(prg_write), .irq(irq16), .count(count16), .prescaler(pre16)
    );

    function automatic void model_edge();
        int rise;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_en[k] = 0; m_pend[k] = 0; m_src[k] = 0; m_small[k] = 0;
                m_rel_en[k] = 0; m_dir[k] = 0; m_xor[k] = 0; m_pre[k] = 0;
                m_cnt[k] = 0; m_rel[k] = 0;
            end
            m_old_a12 = 0;
            m_low_run = 0;
            return;
        end
        rise = (ppu_ce && a12 && m_old_a12 == 0) ? 1 : 0;
`ifdef MAPPER_IRQ_A12_FILTER_EN
        if (m_low_run < LOW_MIN) rise = 0;
`endif
        for (int k = 0; k < 2; k++) begin
            int cmax = 1 << cw[k];
            int d    = (int'(reg_din) ^ m_xor[k]) & 255;
            int wr   = (ce && reg_wr) ? 1 : 0;
            int dis  = (wr && (reg_addr == 2 || (reg_addr == 0 && !reg_din[0]))) ? 1 : 0;
            int enw  = (wr && (reg_addr == 3 || (reg_addr == 0 && reg_din[0]))) ? 1 : 0;
            int ld   = (wr && (reg_addr == 4 || reg_addr == 5 || (reg_addr == 7 && cw[k] > 8))) ? 1 : 0;
            int ev   = 0;
            case (m_src[k])
                0: ev = ce ? 1 : 0;
                1: ev = rise;
                2: ev = (ppu_ce && chr_read) ? 1 : 0;
                default: ev = (ce && prg_write) ? 1 : 0;
            endcase
            if (ev == 1 && m_en[k] == 1 && (m_dir[k] == 1 || m_dir[k] == 2) && dis == 0 && ld == 0) begin
                int up    = (m_dir[k] == 1) ? 1 : 0;
                int pm    = m_small[k] ? 8 : 256;
                int carry = up ? ((m_pre[k] % pm) == pm - 1) : ((m_pre[k] % pm) == 0);
                m_pre[k] = (m_pre[k] + (up ? 1 : 255)) % 256;
                if (carry) begin
                    int term = up ? (m_cnt[k] == cmax - 1) : (m_cnt[k] == 0);
                    if (term) m_pend[k] = 1;
                    if (term && m_rel_en[k]) m_cnt[k] = m_rel[k];
                    else m_cnt[k] = (m_cnt[k] + (up ? 1 : cmax - 1)) % cmax;
                end
            end
            if (dis) begin
                m_en[k] = 0; m_pend[k] = 0; m_pre[k] = 0;
            end else if (wr) begin
                if (enw) m_en[k] = 1;
                case (reg_addr)
                    1: begin
                        m_src[k]    = reg_din % 4;
                        m_small[k]  = (reg_din / 4) % 2;
                        m_rel_en[k] = (reg_din / 8) % 2;
                        m_dir[k]    = reg_din / 64;
                    end
                    4: m_pre[k] = d;
                    5: begin
                        m_cnt[k] = m_cnt[k] - (m_cnt[k] % 256) + d;
                        m_rel[k] = m_rel[k] - (m_rel[k] % 256) + d;
                    end
                    6: m_xor[k] = reg_din;
                    7: if (cw[k] > 8) begin
                        m_cnt[k] = ((m_cnt[k] % 256) + d * 256) % cmax;
                        m_rel[k] = ((m_rel[k] % 256) + d * 256) % cmax;
                    end
                    default: ;
                endcase
            end
        end
        if (ppu_ce) begin
            if (a12) m_low_run = 0;
            else if (m_low_run < LOW_MIN) m_low_run++;
            m_old_a12 = a12 ? 1 : 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("irq8",   {31'd0, irq8},  m_pend[0] & m_en[0]);
        chk("count8", {24'd0, count8}, m_cnt[0]);
        chk("pre8",   {24'd0, pre8},  m_pre[0]);
        chk("irq16",  {31'd0, irq16}, m_pend[1] & m_en[1]);
        chk("count16",{16'd0, count16}, m_cnt[1]);
        chk("pre16",  {24'd0, pre16}, m_pre[1]);
    endtask

    // one clock: model the coming edge, then sample #1 after it
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr_reg(input logic [2:0] addr, input logic [7:0] din);
        ce = 1'b1; reg_wr = 1'b1; reg_addr = addr; reg_din = din;
        step();
        reg_wr = 1'b0; ce = 1'b0;
    endtask

    task automatic run_m2(input int n);
        ce = 1'b1;
        for (int i = 0; i < n; i++) step();
        ce = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 0; ppu_ce = 0; reg_wr = 0; reg_addr = 0; reg_din = 0;
        a12 = 0; chr_read = 0; prg_write = 0;
        step(); step();
        chk("rst_irq8", {31'd0, irq8}, 0);
        chk("rst_count16", {16'd0, count16}, 0);
        reset = 1'b0;

        // M2, down, full prescaler, count 2: expiry on tick 513
        wr_reg(3'd6, 8'h00); wr_reg(3'd1, 8'h80); wr_reg(3'd4, 8'h00);
        wr_reg(3'd5, 8'h02); wr_reg(3'd7, 8'h00); wr_reg(3'd3, 8'h00);
        run_m2(512);
        chk("t1_irq_at512", {31'd0, irq8}, 0);
        chk("t1_cnt_at512", {24'd0, count8}, 8'h00);
        run_m2(1);
        chk("t1_irq_at513", {31'd0, irq8}, 1);
        chk("t1_cnt_at513", {24'd0, count8}, 8'hFF);
        chk("t1_pre_at513", {24'd0, pre8}, 8'hFF);
        chk("t1_cnt16_at513", {16'd0, count16}, 16'hFFFF);

        // up, small prescaler, xor 0x55, count FE, prescaler 0x52^0x55 = 07
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd6, 8'h55); wr_reg(3'd1, 8'h44); wr_reg(3'd4, 8'h52);
        wr_reg(3'd5, 8'hAB); wr_reg(3'd7, 8'h55); wr_reg(3'd3, 8'h00);
        run_m2(1);
        chk("t2_cnt_tick1", {24'd0, count8}, 8'hFF);
        run_m2(7);
        chk("t2_irq_tick8", {31'd0, irq8}, 0);
        run_m2(1);
        chk("t2_irq_tick9", {31'd0, irq8}, 1);
        chk("t2_cnt_wrap", {24'd0, count8}, 8'h00);
        chk("t2_cnt16", {16'd0, count16}, 16'h0100);
        // same with auto-reload
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd1, 8'h4C); wr_reg(3'd4, 8'h52); wr_reg(3'd5, 8'hAB);
        wr_reg(3'd7, 8'h55); wr_reg(3'd3, 8'h00);
        run_m2(9);
        chk("t2r_irq", {31'd0, irq8}, 1);
        chk("t2r_cnt_reload", {24'd0, count8}, 8'hFE);

        // 16-bit: count 1, down, small prescaler from 7 -> expiry on tick 16
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd6, 8'h00); wr_reg(3'd1, 8'h84); wr_reg(3'd4, 8'h07);
        wr_reg(3'd5, 8'h01); wr_reg(3'd7, 8'h00); wr_reg(3'd3, 8'h00);
        run_m2(15);
        chk("t3_irq16_tick15", {31'd0, irq16}, 0);
        run_m2(1);
        chk("t3_irq16_tick16", {31'd0, irq16}, 1);
        chk("t3_cnt16_wrap", {16'd0, count16}, 16'hFFFF);
        wr_reg(3'd2, 8'h00);   // disable coincident with an M2 tick
        chk("t3_dis_irq16", {31'd0, irq16}, 0);
        chk("t3_dis_pre16", {24'd0, pre16}, 0);

        // A12 source, rise after only two low samples
        wr_reg(3'd1, 8'h81); wr_reg(3'd4, 8'h00); wr_reg(3'd5, 8'h05); wr_reg(3'd7, 8'h00);
        ppu_ce = 1; a12 = 1; step();
        ppu_ce = 0; a12 = 0;
        wr_reg(3'd3, 8'h00);
        ppu_ce = 1; a12 = 0; step(); step();
        a12 = 1; step();
        ppu_ce = 0; a12 = 0; step();
`ifdef MAPPER_IRQ_A12_FILTER_EN
        chk("t4_a12_filtered", {24'd0, count8}, 8'h05);
`else
        chk("t4_a12_counted", {24'd0, count8}, 8'h04);
`endif

        // paused direction with continuous M2
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd5, 8'h33); wr_reg(3'd7, 8'h00); wr_reg(3'd4, 8'h11);
        wr_reg(3'd1, 8'hC0); wr_reg(3'd3, 8'h00);
        run_m2(1000);
        chk("t5_cnt_paused", {24'd0, count8}, 8'h33);
        chk("t5_pre_paused", {24'd0, pre8}, 8'h11);
        chk("t5_irq_paused", {31'd0, irq8}, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ce        = 1'($urandom_range(0, 1));
            ppu_ce    = 1'($urandom_range(0, 1));
            a12       = 1'($urandom_range(0, 1));
            chr_read  = 1'($urandom_range(0, 1));
            prg_write = 1'($urandom_range(0, 1));
            reg_wr    = ($urandom_range(0, 9) == 0);
            reg_addr  = 3'($urandom_range(0, 7));
            reg_din   = 8'($urandom);
            if (reg_addr == 3'd2 && $urandom_range(0, 1) == 1) reg_addr = 3'd3;
            step();
        end
        ce = 0; ppu_ce = 0; a12 = 0; chr_read = 0; prg_write = 0; reg_wr = 0;

        // reset while irq is asserted
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd6, 8'h00); wr_reg(3'd1, 8'h44); wr_reg(3'd4, 8'h07);
        wr_reg(3'd5, 8'hFF); wr_reg(3'd7, 8'hFF); wr_reg(3'd3, 8'h00);
        run_m2(1);
        chk("t6_irq_before_rst", {31'd0, irq8}, 1);
        chk("t6_irq16_before_rst", {31'd0, irq16}, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_irq_after_rst", {31'd0, irq8}, 0);
        chk("t6_cnt_after_rst", {24'd0, count8}, 0);
        wr_reg(3'd3, 8'h00);
        run_m2(5);
        chk("t6_mode0_cnt", {16'd0, count16}, 0);
        chk("t6_mode0_pre", {24'd0, pre8}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
